// File: rtl/maxpool_controller_if.sv
// Pixel stream bundle for the 2x2 max-pool controller: one input stream, one output stream.
// Handshake: a beat transfers on a rising clk edge where valid && ready; the source holds valid/data until then.
interface maxpool_controller_if;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/maxpool_controller.sv
// 2x2 / stride-2 max pooling over a raster pixel stream, using one line buffer for the even row.
// The odd row pairs each incoming pixel with the buffered row to close a window every two pixels.
module maxpool_max4 (
    input  logic signed [7:0] a,
    input  logic signed [7:0] b,
    input  logic signed [7:0] c,
    input  logic signed [7:0] d,
    output logic signed [7:0] y
);
    logic signed [7:0] m0;
    logic signed [7:0] m1;

    always_comb begin
        m0 = (a > b) ? a : b;
        m1 = (c > d) ? c : d;
        y  = (m0 > m1) ? m0 : m1;
    end
endmodule

module maxpool_controller #(
    parameter int MAX_W    = 32,
    parameter int DIM_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DIM_BITS-1:0] img_w,
    input  logic [DIM_BITS-1:0] img_h,
    maxpool_controller_if.slave stream,
    output logic                busy,
    output logic                done,
    output logic [2:0]          dbg_state
);
    localparam int AW = (MAX_W > 2) ? $clog2(MAX_W) : 1;
    localparam logic [DIM_BITS-1:0] ONE    = DIM_BITS'(1);
    localparam logic [DIM_BITS-1:0] TWO    = DIM_BITS'(2);
    localparam logic [DIM_BITS:0]   MAXW_C = (DIM_BITS+1)'(MAX_W);

    typedef enum logic [2:0] {IDLE, EVEN_ROW, ODD_ROW, DRAIN, DONE} state_t;

    state_t              state;
    logic [DIM_BITS-1:0] w;
    logic [DIM_BITS-1:0] h;
    logic [DIM_BITS-1:0] col;
    logic [DIM_BITS-1:0] row;
    logic                tail;
    logic signed [7:0]   held;
    logic signed [7:0]   lb [MAX_W];
    logic                out_valid_q;
    logic signed [7:0]   out_data_q;
    logic                in_ready_c;
    logic signed [7:0]   win_max;

    logic [DIM_BITS-1:0] w_last;
    logic [DIM_BITS-1:0] h_m1;
    logic [DIM_BITS-1:0] h_m2;
    logic [AW-1:0]       col_idx;
    logic [AW-1:0]       pair_idx;
    logic                cfg_bad;
    logic                accept;
    logic                window_done;
    logic                out_taken;
    logic                last_col_odd_w;

    assign w_last         = w - ONE;
    assign h_m1           = h - ONE;
    assign h_m2           = h - TWO;
    assign col_idx        = AW'(col);
    assign pair_idx       = {col_idx[AW-1:1], 1'b0};
    assign cfg_bad        = ({1'b0, img_w} > MAXW_C) || (img_w < TWO) || (img_h < TWO);
    assign accept         = stream.in_valid && in_ready_c;
    assign out_taken      = out_valid_q && stream.out_ready;
    // With an odd width the trailing pixel of a row sits at an even column and closes nothing.
    assign last_col_odd_w = w[0] && (col == w_last);
    // Every odd column of an odd row closes a window.
    assign window_done    = (state == ODD_ROW) && col[0] && accept;

    // Stall only the pixel that would overwrite a result nobody has taken yet.
    always_comb begin
        in_ready_c = 1'b0;
        if ((state == EVEN_ROW || state == ODD_ROW || state == DRAIN) && !tail) begin
            in_ready_c = !((state == ODD_ROW) && col[0] && out_valid_q && !stream.out_ready);
        end
    end

    maxpool_max4 u_max4 (
        .a (lb[pair_idx]),
        .b (lb[col_idx]),
        .c (held),
        .d (stream.in_data),
        .y (win_max)
    );

    always_ff @(posedge clk) begin
        if (state == EVEN_ROW && accept && !last_col_odd_w) begin
            lb[col_idx] <= stream.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            w           <= '0;
            h           <= '0;
            col         <= '0;
            row         <= '0;
            tail        <= 1'b0;
            held        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (window_done) begin
                out_valid_q <= 1'b1;
                out_data_q  <= win_max;
            end else if (out_taken) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        w    <= img_w;
                        h    <= img_h;
                        col  <= '0;
                        row  <= '0;
                        tail <= 1'b0;
                        busy <= 1'b1;
                        if (cfg_bad) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= EVEN_ROW;
                        end
                    end
                end
                EVEN_ROW: begin
                    if (accept) begin
                        if (col == w_last) begin
                            col   <= '0;
                            row   <= row + ONE;
                            state <= ODD_ROW;
                        end else begin
                            col <= col + ONE;
                        end
                    end
                end
                ODD_ROW: begin
                    // tail: every pixel consumed, waiting for the final result to leave.
                    if (tail) begin
                        if (!out_valid_q || out_taken) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (accept) begin
                        if (!col[0] && !last_col_odd_w) begin
                            held <= stream.in_data;
                        end
                        if (col == w_last) begin
                            col <= '0;
                            row <= row + ONE;
                            if (row == h_m1) begin
                                tail <= 1'b1;
                            end else if (row == h_m2) begin
                                state <= DRAIN;
                            end else begin
                                state <= EVEN_ROW;
                            end
                        end else begin
                            col <= col + ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (tail) begin
                        if (!out_valid_q || out_taken) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (accept) begin
                        if (col == w_last) begin
                            col  <= '0;
                            tail <= 1'b1;
                        end else begin
                            col <= col + ONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tail  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stream.in_ready  = in_ready_c;
    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data_q;
    assign dbg_state        = state;
endmodule
